order_scheduler: RTL and testbench
==================================

ORDER_SCHEDULER -- requirements
Module: order_scheduler

Interface
REQ-001 SHALL have parameter FRAMES_PER_SEC, default 60, vsync frames per game second.
REQ-002 SHALL have parameter SPAWN_PERIOD, default 8, game seconds between spawn attempts.
REQ-003 SHALL have parameter ORDER_LIFE, default 20, initial seconds on a new order (max 31).
REQ-004 SHALL have port clock  in  1  the single system clock.
REQ-005 SHALL have port reset  in  1  asynchronous, active-low reset.
REQ-006 SHALL have port vsync  in  1  frame strobe, rising edge counts one frame.
REQ-007 SHALL have port timer_go  in  1  game running enable.
REQ-008 SHALL have port check_spaces  in  2x4  dish code on serving space 0/1, 0 = empty.
REQ-009 SHALL have port clear_space0 / clear_space1  out  1  one-cycle pulse consuming the dish on that space.
REQ-010 SHALL have port orders  out  4  per-slot valid.
REQ-011 SHALL have port order_dishes  out  4x4  dish code per slot.
REQ-012 SHALL have port order_times  out  4x5  remaining seconds per slot.
REQ-013 SHALL have port point_total  out  10  score.
REQ-014 SHALL have port expired_pulse  out  1  one-cycle pulse when any order expires.

Function
REQ-015 SHALL detect vsync rising edge with a registered copy; frame counter wraps at FRAMES_PER_SEC-1, producing one-cycle sec_tick, only while timer_go=1.
REQ-016 SHALL, while timer_go=0, freeze frame/spawn counters and slot timers and keep the serve FSM in IDLE.
REQ-017 SHALL, on sec_tick, decrement order_times of every valid slot with time>0; valid slot at time 0 on sec_tick is cleared and raises expired_pulse.
REQ-018 SHALL count sec_ticks in a spawn counter; on tick where it equals SPAWN_PERIOD-1 it wraps and spawns into the lowest-index free slot: valid=1, time=ORDER_LIFE, dish from LFSR.
REQ-019 SHALL drop the spawn silently when all four slots are valid; counter still wraps.
REQ-020 SHALL derive dish = lfsr[2:0], mapped 0->1, giving codes 1..7; LFSR free-runs every cycle.
REQ-021 SHALL run serve FSM IDLE->MATCH->CLEAR->HOLD->IDLE.
REQ-022 IDLE: grant a nonzero space; if both nonzero, round-robin pointer decides, pointer toggles after each grant.
REQ-023 MATCH (1 cycle): find lowest-index valid slot whose dish equals granted space code; none -> IDLE, no clear, no score.
REQ-024 CLEAR: pulse clear_spaceN for exactly one cycle, clear matched slot, add 20 points.
REQ-025 HOLD: wait until granted space reads 0, then IDLE; request-to-clear latency is exactly 2 cycles.
REQ-026 SHALL give serve priority over expiry on the same slot in the same cycle (score, no expired_pulse).
REQ-027 SHALL spawn only into slots free at the start of the cycle; a slot freed that cycle is not reused until next cycle.
REQ-028 SHALL saturate point_total at 1023 and 0; simultaneous +20 and penalty apply as net change.

Reset
REQ-029 SHALL, on reset=0, asynchronously clear all outputs, counters, slots, FSM to IDLE, RR pointer to space 0, LFSR to 8'hA5.
REQ-030 SHALL abandon any in-progress serve on reset with no clear pulse emitted.

Configuration
REQ-031 SHALL, with ORDER_SCHED_PENALTY_EN defined, subtract 10 points (floor 0) per expiry; without it, expiry only clears the slot and pulses expired_pulse.

Structure
REQ-032 SHALL take dish_t (4-bit), NUM_SLOTS=4, SERVE_POINTS=20, EXPIRE_PENALTY=10 and the FSM state enum from shared package order_pkg.
REQ-033 SHALL instantiate sub-module lfsr8 (taps x^8+x^6+x^5+x^4+1, seed input).

Verification
REQ-034 FRAMES_PER_SEC=2, SPAWN_PERIOD=2, timer_go=1, 4 vsync edges -> orders=4'b0001, order_times[0]=ORDER_LIFE, order_dishes[0] in 1..7.
REQ-035 check_spaces[0]=order_dishes[0] in IDLE at cycle N -> clear_space0=1 at N+2 only, orders[0]=0, point_total=20.
REQ-036 both spaces hold matching dishes for slots 0,1 -> clear_space0 first, clear_space1 after space 0 reads 0, point_total=40.
REQ-037 unserved order, ORDER_LIFE+1 sec_ticks -> expired_pulse once, orders[0]=0; point_total 0 stays 0 with macro, 30->20 with macro, 30->30 without.
REQ-038 four slots full, further spawn ticks -> orders stays 4'hF, contents unchanged; reset=0 mid-HOLD -> all outputs 0 at once, no clear pulse.

Source files
------------

// File: rtl/order_pkg.sv
`default_nettype none
// ============================================================================
// Package  : order_pkg
// Brief    : Shared types and constants for the order scheduler.
// Revision : 1.0 - initial release
// ============================================================================
package order_pkg;

    typedef logic [3:0] dish_t;

    localparam int NUM_SLOTS      = 4;
    localparam int SERVE_POINTS   = 20;
    localparam int EXPIRE_PENALTY = 10;

    typedef enum logic [1:0] {
        SERVE_IDLE  = 2'd0,
        SERVE_MATCH = 2'd1,
        SERVE_CLEAR = 2'd2,
        SERVE_HOLD  = 2'd3
    } serve_state_e;

    // Dish code 0 means "empty space", so a zero LFSR draw is folded onto 1.
    function automatic dish_t lfsr_to_dish(input logic [2:0] v);
        return (v == 3'd0) ? 4'd1 : {1'b0, v};
    endfunction

endpackage
`default_nettype wire

// File: rtl/lfsr8.sv
`default_nettype none
// ============================================================================
// Module   : lfsr8
// Brief    : Free-running 8-bit Fibonacci LFSR, x^8+x^6+x^5+x^4+1, seeded on reset.
// Revision : 1.0 - initial release
// ============================================================================
module lfsr8 #(
    parameter int OUT_W = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [7:0]       seed,
    output logic [OUT_W-1:0] lfsr
);
    logic [7:0] lfsr_q;
    logic [7:0] lfsr_d;

    always_comb begin
        lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            lfsr_q <= seed;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign lfsr = lfsr_q[OUT_W-1:0];

endmodule
`default_nettype wire

// File: rtl/order_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : order_scheduler
// Brief    : Spawns timed dish orders into four slots and serves them from two
//            serving spaces, keeping a saturating score.
// Options  : ORDER_SCHED_PENALTY_EN - deduct points for every expired order
// Revision : 1.0 - initial release
// ============================================================================
module order_scheduler
    import order_pkg::*;
#(
    parameter int FRAMES_PER_SEC = 60,
    parameter int SPAWN_PERIOD   = 8,
    parameter int ORDER_LIFE     = 20
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        vsync,
    input  logic        timer_go,
    input  logic [7:0]  check_spaces,
    output logic        clear_space0,
    output logic        clear_space1,
    output logic [3:0]  orders,
    output logic [15:0] order_dishes,
    output logic [19:0] order_times,
    output logic [9:0]  point_total,
    output logic        expired_pulse
);
    localparam int FRAME_W = (FRAMES_PER_SEC > 1) ? $clog2(FRAMES_PER_SEC) : 1;
    localparam int SPAWN_W = (SPAWN_PERIOD > 1) ? $clog2(SPAWN_PERIOD) : 1;
    localparam int SLOT_W  = $clog2(NUM_SLOTS);
    localparam logic [FRAME_W-1:0] FRAME_LAST = FRAME_W'(FRAMES_PER_SEC - 1);
    localparam logic [SPAWN_W-1:0] SPAWN_LAST = SPAWN_W'(SPAWN_PERIOD - 1);
    localparam logic [4:0]         LIFE_INIT  = 5'(ORDER_LIFE);
    localparam logic [7:0]         LFSR_SEED  = 8'hA5;
    localparam logic [9:0]         POINT_MAX  = 10'd1023;

    logic                          vsync_q;
    logic [FRAME_W-1:0]            frame_q, frame_d;
    logic [SPAWN_W-1:0]            spawn_q, spawn_d;
    logic [NUM_SLOTS-1:0]          valid_q, valid_d;
    dish_t [NUM_SLOTS-1:0]         dish_q, dish_d;
    logic [NUM_SLOTS-1:0][4:0]     time_q, time_d;
    serve_state_e                  state_q, state_d;
    logic                          grant_q, grant_d;
    logic                          rr_q, rr_d;
    logic [SLOT_W-1:0]             match_q, match_d;
    logic [9:0]                    points_q, points_d;
    logic                          expired_q, expired_d;

    logic [2:0]                    lfsr_low;
    logic                          frame_tick, sec_tick, spawn_now;
    dish_t                         space0, space1, granted_code;
    logic                          hit_found, free_found, protect_en, served;
    logic [SLOT_W-1:0]             hit_idx, free_idx, protect_idx;
    logic [2:0]                    expire_cnt;
    logic [11:0]                   gain, penalty, sum, net;

    lfsr8 #(
        .OUT_W (3)
    ) u_lfsr (
        .clock (clock),
        .reset (reset),
        .seed  (LFSR_SEED),
        .lfsr  (lfsr_low)
    );

    assign space0       = check_spaces[3:0];
    assign space1       = check_spaces[7:4];
    assign granted_code = grant_q ? space1 : space0;

    always_comb begin
        frame_tick = timer_go & vsync & ~vsync_q;
        sec_tick   = frame_tick & (frame_q == FRAME_LAST);
        spawn_now  = sec_tick & (spawn_q == SPAWN_LAST);
        frame_d    = frame_q;
        spawn_d    = spawn_q;
        if (frame_tick) begin
            frame_d = sec_tick ? '0 : frame_q + 1'b1;
        end
        if (sec_tick) begin
            spawn_d = spawn_now ? '0 : spawn_q + 1'b1;
        end
    end

    // Lowest-index valid slot holding the granted dish; lowest free slot for spawns.
    always_comb begin
        hit_found  = 1'b0;
        hit_idx    = '0;
        free_found = 1'b0;
        free_idx   = '0;
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            if (valid_q[i] && (dish_q[i] == granted_code)) begin
                hit_found = 1'b1;
                hit_idx   = SLOT_W'(i);
            end
            if (!valid_q[i]) begin
                free_found = 1'b1;
                free_idx   = SLOT_W'(i);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        rr_d    = rr_q;
        match_d = match_q;
        case (state_q)
            SERVE_IDLE: begin
                if ((space0 != 4'd0) || (space1 != 4'd0)) begin
                    grant_d = ((space0 != 4'd0) && (space1 != 4'd0)) ? rr_q : (space1 != 4'd0);
                    rr_d    = ~rr_q;
                    state_d = SERVE_MATCH;
                end
            end
            SERVE_MATCH: begin
                match_d = hit_idx;
                state_d = hit_found ? SERVE_CLEAR : SERVE_IDLE;
            end
            SERVE_CLEAR: state_d = SERVE_HOLD;
            SERVE_HOLD: begin
                if (granted_code == 4'd0) begin
                    state_d = SERVE_IDLE;
                end
            end
            default: state_d = SERVE_IDLE;
        endcase
        if (!timer_go) begin
            state_d = SERVE_IDLE;
        end
    end

    // A slot being served cannot expire underneath the serve.
    always_comb begin
        protect_en  = (state_q == SERVE_CLEAR) || ((state_q == SERVE_MATCH) && hit_found);
        protect_idx = (state_q == SERVE_CLEAR) ? match_q : hit_idx;
        served      = (state_q == SERVE_CLEAR);
        valid_d     = valid_q;
        dish_d      = dish_q;
        time_d      = time_q;
        expire_cnt  = 3'd0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (valid_q[i] && sec_tick) begin
                if (time_q[i] != 5'd0) begin
                    time_d[i] = time_q[i] - 5'd1;
                end else if (!(protect_en && (protect_idx == SLOT_W'(i)))) begin
                    valid_d[i] = 1'b0;
                    expire_cnt = expire_cnt + 3'd1;
                end
            end
        end
        if (served) begin
            valid_d[match_q] = 1'b0;
        end
        if (spawn_now && free_found) begin
            valid_d[free_idx] = 1'b1;
            time_d[free_idx]  = LIFE_INIT;
            dish_d[free_idx]  = lfsr_to_dish(lfsr_low);
        end
        expired_d = (expire_cnt != 3'd0);
    end

    always_comb begin
        gain = served ? 12'(SERVE_POINTS) : 12'd0;
`ifdef ORDER_SCHED_PENALTY_EN
        penalty = 12'(EXPIRE_PENALTY) * {9'd0, expire_cnt};
`else
        penalty = 12'd0;
`endif
        sum = {2'b00, points_q} + gain;
        net = sum - penalty;
        if (sum < penalty) begin
            points_d = '0;
        end else if (net > {2'b00, POINT_MAX}) begin
            points_d = POINT_MAX;
        end else begin
            points_d = net[9:0];
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            vsync_q   <= 1'b0;
            frame_q   <= '0;
            spawn_q   <= '0;
            valid_q   <= '0;
            dish_q    <= '0;
            time_q    <= '0;
            state_q   <= SERVE_IDLE;
            grant_q   <= 1'b0;
            rr_q      <= 1'b0;
            match_q   <= '0;
            points_q  <= '0;
            expired_q <= 1'b0;
        end else begin
            vsync_q   <= vsync;
            frame_q   <= frame_d;
            spawn_q   <= spawn_d;
            valid_q   <= valid_d;
            dish_q    <= dish_d;
            time_q    <= time_d;
            state_q   <= state_d;
            grant_q   <= grant_d;
            rr_q      <= rr_d;
            match_q   <= match_d;
            points_q  <= points_d;
            expired_q <= expired_d;
        end
    end

    assign clear_space0  = (state_q == SERVE_CLEAR) && !grant_q;
    assign clear_space1  = (state_q == SERVE_CLEAR) && grant_q;
    assign orders        = valid_q;
    assign order_dishes  = dish_q;
    assign order_times   = time_q;
    assign point_total   = points_q;
    assign expired_pulse = expired_q;

endmodule
`default_nettype wire

// File: tb/tb_order_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_order_scheduler
// Brief    : Directed self-checking bench for order_scheduler with a serve scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_order_scheduler;
    localparam int FPS  = 2;
    localparam int SP   = 2;
    localparam int LIFE = 20;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        vsync = 1'b0;
    logic        timer_go = 1'b0;
    logic [7:0]  check_spaces = 8'd0;
    logic        clear_space0, clear_space1;
    logic [3:0]  orders;
    logic [15:0] order_dishes;
    logic [19:0] order_times;
    logic [9:0]  point_total;
    logic        expired_pulse;

    order_scheduler #(
        .FRAMES_PER_SEC (FPS),
        .SPAWN_PERIOD   (SP),
        .ORDER_LIFE     (LIFE)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .vsync         (vsync),
        .timer_go      (timer_go),
        .check_spaces  (check_spaces),
        .clear_space0  (clear_space0),
        .clear_space1  (clear_space1),
        .orders        (orders),
        .order_dishes  (order_dishes),
        .order_times   (order_times),
        .point_total   (point_total),
        .expired_pulse (expired_pulse)
    );

    always #5 clock = ~clock;

    // Reference LFSR: x^8+x^6+x^5+x^4+1, seed 8'hA5.
    logic [7:0] m_lfsr;
    always @(posedge clock or negedge reset) begin
        if (!reset) m_lfsr <= 8'hA5;
        else        m_lfsr <= {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
    end

    typedef struct {
        int sp;
        int lat;
        int pts;
    } serve_t;

    serve_t     sb[$];
    int         checks = 0;
    int         errors = 0;
    int         exp_seen = 0;
    logic [3:0] last_cap;
    logic [3:0] tick_dish;

    function automatic logic [3:0] dish_of(input logic [7:0] v);
        return (v[2:0] == 3'd0) ? 4'd1 : {1'b0, v[2:0]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic expect_clear(input int sp, input int lat, input int pts);
        serve_t e;
        e.sp  = sp;
        e.lat = lat;
        e.pts = pts;
        sb.push_back(e);
    endtask

    task automatic frame();
        vsync    = 1'b1;
        last_cap = dish_of(m_lfsr);
        @(posedge clock); #1;
        vsync = 1'b0;
        @(negedge clock);
        if (expired_pulse) exp_seen++;
        @(posedge clock); #1;
    endtask

    task automatic second();
        frame();
        frame();
        tick_dish = last_cap;
    endtask

    task automatic do_reset();
        reset        = 1'b0;
        vsync        = 1'b0;
        timer_go     = 1'b0;
        check_spaces = 8'd0;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b1;
        @(posedge clock); #1;
        exp_seen = 0;
    endtask

    // Watches clear pulses, pops the scoreboard per pulse and optionally consumes the dish.
    task automatic watch(input int cycles, input bit consume);
        serve_t e;
        int     sp;
        int     zero_sp;
        int     pts_exp;
        bit     pts_due;
        zero_sp = -1;
        pts_exp = 0;
        pts_due = 1'b0;
        for (int c = 1; c <= cycles; c++) begin
            @(negedge clock);
            if (pts_due) begin
                chk("points_after_serve", point_total, pts_exp);
                pts_due = 1'b0;
            end
            if (clear_space0 || clear_space1) begin
                sp = clear_space1 ? 1 : 0;
                checks++;
                assert (sb.size() > 0) else begin
                    errors++;
                    $error("FAIL unexpected_clear: observed clear0=%0b clear1=%0b expected none",
                           clear_space0, clear_space1);
                end
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    chk("clear_space", {clear_space1, clear_space0}, (e.sp == 1) ? 2'b10 : 2'b01);
                    if (e.lat >= 0) chk("clear_latency", c - 1, e.lat);
                    pts_exp = e.pts;
                    pts_due = 1'b1;
                    if (consume) zero_sp = sp;
                end
            end
            @(posedge clock); #1;
            if (zero_sp == 0) check_spaces[3:0] = 4'd0;
            if (zero_sp == 1) check_spaces[7:4] = 4'd0;
            zero_sp = -1;
        end
        checks++;
        assert (sb.size() == 0) else begin
            errors++;
            $error("FAIL missing_clear: observed %0d pending expected 0", sb.size());
        end
        sb.delete();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: observed no finish expected finish");
        $fatal(1, "simulation timeout");
    end

    initial begin
        logic [3:0] d0, d1, s0a, s1, s0b, s2, s3;
        int         pts_exp;

        // Reset state
        repeat (3) @(posedge clock);
        #1;
        chk("reset_orders", orders, 4'd0);
        chk("reset_dishes", order_dishes, 16'd0);
        chk("reset_times", order_times, 20'd0);
        chk("reset_points", point_total, 10'd0);
        chk("reset_clears", {clear_space1, clear_space0}, 2'b00);
        chk("reset_expired", expired_pulse, 1'b0);
        reset = 1'b1;
        @(posedge clock); #1;

        // First spawn after two game seconds
        timer_go = 1'b1;
        second();
        second();
        d0 = tick_dish;
        chk("spawn_orders", orders, 4'b0001);
        chk("spawn_time", order_times[4:0], LIFE);
        chk("spawn_dish", order_dishes[3:0], d0);

        // Paused: timers frozen, no serving
        timer_go = 1'b0;
        repeat (3) frame();
        chk("frozen_time", order_times[4:0], LIFE);
        check_spaces[3:0] = d0;
        watch(6, 1'b1);
        check_spaces[3:0] = d0;

        // Resume: serve lands two cycles later
        expect_clear(0, 2, 20);
        timer_go = 1'b1;
        watch(10, 1'b1);
        chk("served_orders", orders, 4'b0000);

        // Two spaces, round-robin starts at space 0
        do_reset();
        timer_go = 1'b1;
        second(); second(); d0 = tick_dish;
        second(); second(); d1 = tick_dish;
        chk("two_orders", orders, 4'b0011);
        check_spaces = {d1, d0};
        expect_clear(0, 2, 20);
        expect_clear(1, -1, 40);
        watch(20, 1'b1);
        chk("two_served_orders", orders, 4'b0000);
        chk("two_served_points", point_total, 10'd40);

        // Fill all slots, drop spawns, then expire one order
        do_reset();
        timer_go = 1'b1;
        second(); second(); s0a = tick_dish;
        second(); second(); s1 = tick_dish;
        check_spaces[3:0] = s0a;
        expect_clear(0, 2, 20);
        watch(10, 1'b1);
        second(); second(); s0b = tick_dish;
        second(); second(); s2 = tick_dish;
        second(); second(); s3 = tick_dish;
        second(); second();
        chk("full_orders", orders, 4'hF);
        chk("full_dishes", order_dishes, {s3, s2, s1, s0b});
        chk("full_times", order_times, {5'd18, 5'd16, 5'd12, 5'd14});
        repeat (12) second();
        chk("pre_expiry_pulses", exp_seen, 0);
        chk("pre_expiry_orders", orders, 4'hF);
        second();
`ifdef ORDER_SCHED_PENALTY_EN
        pts_exp = 10;
`else
        pts_exp = 20;
`endif
        chk("expiry_pulses", exp_seen, 1);
        chk("expiry_orders", orders, 4'b1101);
        chk("expiry_slot0_time", order_times[4:0], 5'd1);
        chk("expiry_points", point_total, pts_exp);

        // Reset while holding after a serve
        do_reset();
        timer_go = 1'b1;
        second(); second(); d0 = tick_dish;
        check_spaces[3:0] = d0;
        expect_clear(0, 2, 20);
        watch(5, 1'b0);
        reset = 1'b0;
        #1;
        chk("hold_reset_orders", orders, 4'd0);
        chk("hold_reset_dishes", order_dishes, 16'd0);
        chk("hold_reset_times", order_times, 20'd0);
        chk("hold_reset_points", point_total, 10'd0);
        chk("hold_reset_clears", {clear_space1, clear_space0}, 2'b00);
        chk("hold_reset_expired", expired_pulse, 1'b0);
        @(posedge clock); #1;
        watch(3, 1'b0);
        reset = 1'b1;
        watch(6, 1'b0);
        chk("post_reset_points", point_total, 10'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
